// File: rtl/turn_pkg.sv
// Shared encodings for the checkers turn sequencer: FSM states, light modes and
// status word bit positions.
package turn_pkg;

  typedef enum logic [1:0] {
    S_SYNC   = 2'd0,
    S_PLAYER = 2'd1,
    S_CPU    = 2'd2,
    S_OVER   = 2'd3
  } state_t;

  localparam logic [1:0] LIGHT_SYNC   = 2'd0;
  localparam logic [1:0] LIGHT_PLAYER = 2'd1;
  localparam logic [1:0] LIGHT_CPU    = 2'd2;
  localparam logic [1:0] LIGHT_OVER   = 2'd3;

  localparam int unsigned STATUS_CPU_DONE  = 0;
  localparam int unsigned STATUS_GAME_OVER = 1;

  function automatic logic [1:0] light_of(state_t s);
    logic [1:0] mode;
    mode = LIGHT_SYNC;
    unique case (s)
      S_SYNC:   mode = LIGHT_SYNC;
      S_PLAYER: mode = LIGHT_PLAYER;
      S_CPU:    mode = LIGHT_CPU;
      S_OVER:   mode = LIGHT_OVER;
      default:  mode = LIGHT_SYNC;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/popcount32.sv
// Combinational population count of a 32-bit word (6-bit result).
module popcount32 (
  input  logic [31:0] value,
  output logic [5:0]  count
);

  always_comb begin
    count = 6'd0;
    for (int i = 0; i < 32; i++) begin
      count = count + 6'(value[i]);
    end
  end

endmodule

// File: rtl/turn_sequencer.sv
// Sequences player/CPU turns from the debounced sensor board and CPU status word.
// Optional CPU-turn watchdog enabled by defining TURN_WATCHDOG_EN.
module turn_sequencer
  import turn_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 200000,
  parameter int unsigned CPU_TIMEOUT   = 100000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] sensor_board,
  input  logic [31:0] player_board,
  input  logic [31:0] cpu_board,
  input  logic [31:0] status_in,
  input  logic        commit_btn,
  output logic        computer_turn,
  output logic [31:0] move_snapshot,
  output logic        snapshot_valid,
  output logic [1:0]  light_mode,
  output logic        move_error,
  output logic        timeout_error
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q, sync3_q, commit_q;
  logic [31:0] sensor_prev_q;
  logic [CntW-1:0] stab_cnt_q;
  logic        done_prev_q;
  logic [31:0] snap_q, snap_d;
  logic        snap_valid_q, snap_valid_d;
  logic        move_err_q, move_err_d;
  logic        timeout_q, timeout_d;

  logic [31:0] expected;
  logic [5:0]  sensor_pop, expected_pop;
  logic        stable, done_rise, game_over, move_ok, wd_expired;
  logic        unused_status;

  assign expected      = player_board | cpu_board;
  assign stable        = (stab_cnt_q == CntW'(STABLE_CYCLES));
  assign game_over     = status_in[STATUS_GAME_OVER];
  assign done_rise     = status_in[STATUS_CPU_DONE] & ~done_prev_q;
  assign unused_status = ^status_in[31:2];

  popcount32 u_pop_sensor (
    .value (sensor_board),
    .count (sensor_pop)
  );

  popcount32 u_pop_expected (
    .value (expected),
    .count (expected_pop)
  );

  assign move_ok = stable && (sensor_board != expected) && (sensor_pop <= expected_pop);

`ifdef TURN_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(CPU_TIMEOUT + 1);

  logic [WdW-1:0] wd_cnt_q;

  // Counter is zero on the first S_CPU cycle because it is held clear elsewhere.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt_q <= '0;
    end else if (state_q != S_CPU) begin
      wd_cnt_q <= '0;
    end else if (!wd_expired) begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
    end
  end

  assign wd_expired = (state_q == S_CPU) && (wd_cnt_q == WdW'(CPU_TIMEOUT - 1));
`else
  logic [31:0] unused_cfg;

  assign unused_cfg = CPU_TIMEOUT;
  assign wd_expired = 1'b0;
`endif

  // Commit button: two synchronizer flops, edge detect, registered pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync3_q  <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      sync1_q  <= commit_btn;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
      commit_q <= sync2_q & ~sync3_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sensor_prev_q <= '0;
      stab_cnt_q    <= '0;
    end else begin
      sensor_prev_q <= sensor_board;
      if (sensor_board != sensor_prev_q) begin
        stab_cnt_q <= '0;
      end else if (!stable) begin
        stab_cnt_q <= stab_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_SYNC;
      done_prev_q  <= 1'b0;
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
      move_err_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      done_prev_q  <= status_in[STATUS_CPU_DONE];
      snap_q       <= snap_d;
      snap_valid_q <= snap_valid_d;
      move_err_q   <= move_err_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    snap_valid_d = 1'b0;
    move_err_d   = move_err_q;
    timeout_d    = timeout_q;
    if (game_over) begin
      state_d = S_OVER;
    end else begin
      unique case (state_q)
        S_SYNC: begin
          if (stable && (sensor_board == expected)) begin
            state_d = S_PLAYER;
          end
        end
        S_PLAYER: begin
          if (commit_q) begin
            if (move_ok) begin
              snap_d       = sensor_board;
              snap_valid_d = 1'b1;
              move_err_d   = 1'b0;
              state_d      = S_CPU;
            end else begin
              move_err_d = 1'b1;
            end
          end
        end
        S_CPU: begin
          if (done_rise) begin
            state_d = S_SYNC;
          end else if (wd_expired) begin
            timeout_d = 1'b1;
            state_d   = S_SYNC;
          end
        end
        S_OVER: state_d = S_OVER;
        default: state_d = S_SYNC;
      endcase
    end
  end

  assign computer_turn  = (state_q == S_CPU);
  assign light_mode     = light_of(state_q);
  assign move_snapshot  = snap_q;
  assign snapshot_valid = snap_valid_q;
  assign move_error     = move_err_q;
  assign timeout_error  = timeout_q;

endmodule
